// File: rtl/async_fsm_emulator.sv
// Table-driven fundamental-mode asynchronous FSM emulator with a run-time programmable {next_y,z} table.
// Optional macro MULTI_CHG_DET_EN enables the multi-bit input change warning pulse (multi_chg).
module async_fsm_emulator #(
    parameter int XW          = 2,
    parameter int YW          = 2,
    parameter int ZW          = 1,
    parameter int MAX_ITER    = 4,
    parameter int RESET_STATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [XW-1:0]    x,
    input  logic             cfg_we,
    input  logic [XW+YW-1:0] cfg_addr,
    input  logic [YW+ZW-1:0] cfg_wdata,
    output logic [YW-1:0]    y,
    output logic [ZW-1:0]    z,
    output logic             stable,
    output logic             busy,
    output logic             osc_err,
    output logic             multi_chg
);

    localparam int AW    = XW + YW;
    localparam int EW    = YW + ZW;
    localparam int DEPTH = 1 << AW;
    localparam int IW    = $clog2(MAX_ITER + 1);

    localparam logic [YW-1:0] RST_Y    = YW'(RESET_STATE);
    localparam logic [IW-1:0] ITER_MAX = IW'(MAX_ITER);

    typedef enum logic [1:0] {
        ST_STABLE = 2'b00,
        ST_SETTLE = 2'b01,
        ST_OSC    = 2'b10
    } state_t;

    state_t          state_r;
    logic [YW-1:0]   y_r;
    logic [XW-1:0]   xs_r;
    logic [IW-1:0]   iter_r;
    logic            osc_err_r;
    logic            stable_r;
    logic            busy_r;
    logic [EW-1:0]   tbl_r [0:DEPTH-1];

    logic [EW-1:0]   entry_s;
    logic [YW-1:0]   next_y_s;
    logic            x_chg_s;

    // Total-state lookup: the table entry addressed by the sampled inputs and current state
    always_comb begin
        entry_s  = tbl_r[{xs_r, y_r}];
        next_y_s = entry_s[EW-1:ZW];
        x_chg_s  = 1'b0;
        if (en && (x != xs_r)) begin
            x_chg_s = 1'b1;
        end else begin
            x_chg_s = 1'b0;
        end
    end

    // Table storage: cleared on reset, written only while input sampling is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_r[i] <= {EW{1'b0}};
            end
        end else if (cfg_we && !en) begin
            tbl_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Settle sequencer: iterates the next-state function until the total state repeats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_STABLE;
            y_r       <= RST_Y;
            xs_r      <= {XW{1'b0}};
            iter_r    <= {IW{1'b0}};
            osc_err_r <= 1'b0;
            stable_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else if (clr) begin
            // clr wins over sampling and settle progress; x is absorbed so no settle follows
            state_r   <= ST_STABLE;
            y_r       <= RST_Y;
            xs_r      <= x;
            iter_r    <= {IW{1'b0}};
            osc_err_r <= 1'b0;
            stable_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_STABLE: begin
                    if (x_chg_s) begin
                        xs_r     <= x;
                        iter_r   <= {IW{1'b0}};
                        state_r  <= ST_SETTLE;
                        stable_r <= 1'b0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= ST_STABLE;
                        stable_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (next_y_s == y_r) begin
                        state_r  <= ST_STABLE;
                        stable_r <= 1'b1;
                        busy_r   <= 1'b0;
                    end else if (iter_r == ITER_MAX) begin
                        // Transition budget exhausted: freeze y where it is
                        state_r   <= ST_OSC;
                        osc_err_r <= 1'b1;
                        stable_r  <= 1'b0;
                        busy_r    <= 1'b0;
                    end else begin
                        y_r    <= next_y_s;
                        iter_r <= iter_r + {{(IW-1){1'b0}}, 1'b1};
                    end
                end
                ST_OSC: begin
                    state_r  <= ST_OSC;
                    stable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ST_STABLE;
                    y_r      <= RST_Y;
                    iter_r   <= {IW{1'b0}};
                    stable_r <= 1'b1;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef MULTI_CHG_DET_EN
    logic multi_chg_r;

    function automatic logic more_than_one(input logic [XW-1:0] v);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < XW; i++) begin
            if (v[i]) begin
                cnt = cnt + 32'd1;
            end
        end
        return (cnt > 32'd1);
    endfunction

    // Fundamental-mode violation warning, raised only on the sampling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_chg_r <= 1'b0;
        end else if (clr) begin
            multi_chg_r <= 1'b0;
        end else if ((state_r == ST_STABLE) && x_chg_s) begin
            multi_chg_r <= more_than_one(x ^ xs_r);
        end else begin
            multi_chg_r <= 1'b0;
        end
    end

    assign multi_chg = multi_chg_r;
`else
    assign multi_chg = 1'b0;
`endif

    assign y       = y_r;
    assign z       = entry_s[ZW-1:0];
    assign stable  = stable_r;
    assign busy    = busy_r;
    assign osc_err = osc_err_r;

endmodule
